// File: rtl/asym_ram_stream_rdwide_if.sv
`default_nettype none
//==============================================================================
// Module : asym_ram_stream_rdwide_if
// Brief  : Write-stream and wide-read bus bundle for asym_ram_stream_rdwide.
//          rd_collide exists only when ASYM_RAM_COLLISION_EN is defined.
// Rev    : 1.0
//==============================================================================
interface asym_ram_stream_rdwide_if #(
   parameter int DATAWIDTHA = 32,
   parameter int DATAWIDTHB = 512,
   parameter int ADDRWIDTHA = 14,
   parameter int ADDRWIDTHB = 10
);
   logic                  wr_start;
   logic [ADDRWIDTHA-1:0] wr_base;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATAWIDTHA-1:0] wr_data;
   logic                  wr_last;
   logic [ADDRWIDTHA-1:0] wr_ptr;
   logic                  wr_done;
   logic                  wr_full;
   logic                  rd_en;
   logic [ADDRWIDTHB-1:0] rd_addr;
   logic [DATAWIDTHB-1:0] rd_data;
   logic                  rd_valid;
`ifdef ASYM_RAM_COLLISION_EN
   logic                  rd_collide;
`endif

   modport master (
      output wr_start, wr_base, wr_valid, wr_data, wr_last, rd_en, rd_addr,
      input  wr_ready, wr_ptr, wr_done, wr_full, rd_data, rd_valid
`ifdef ASYM_RAM_COLLISION_EN
      , input rd_collide
`endif
   );

   modport slave (
      input  wr_start, wr_base, wr_valid, wr_data, wr_last, rd_en, rd_addr,
      output wr_ready, wr_ptr, wr_done, wr_full, rd_data, rd_valid
`ifdef ASYM_RAM_COLLISION_EN
      , output rd_collide
`endif
   );
endinterface
`default_nettype wire

// File: rtl/asym_ram_stream_rdwide.sv
`default_nettype none
//==============================================================================
// Module : asym_ram_stream_rdwide
// Brief  : Asymmetric SDP RAM: narrow streaming loader, wide pipelined reader.
//          Optional read/commit collision flag: define ASYM_RAM_COLLISION_EN.
// Rev    : 1.0
//==============================================================================
module asym_ram_stream_rdwide #(
   parameter int                    DATAWIDTHA = 32,
   parameter int                    DATAWIDTHB = 512,
   parameter int                    SIZEB      = 1024,
   parameter int                    ADDRWIDTHB = 10,
   parameter int                    ADDRWIDTHA = 14,
   parameter int                    RD_LATENCY = 3,
   parameter                        RAM_STYLE  = "block",
   parameter logic [DATAWIDTHA-1:0] INIT_VALUE = 32'h7fff0000
) (
   input wire clk,
   input wire rstn,
   asym_ram_stream_rdwide_if.slave bus
);
   localparam int c_RATIO     = DATAWIDTHB / DATAWIDTHA;
   localparam int c_LANE_BITS = ADDRWIDTHA - ADDRWIDTHB;
   localparam logic [ADDRWIDTHA-1:0] c_TOP_ADDR = ADDRWIDTHA'(SIZEB * c_RATIO - 1);

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_badLatency
         $error("RD_LATENCY must be in 1..8");
      end
      if (c_RATIO < 2 || (1 << c_LANE_BITS) != c_RATIO || c_RATIO * DATAWIDTHA != DATAWIDTHB
          || ADDRWIDTHB != $clog2(SIZEB)) begin : g_badGeometry
         $error("inconsistent width/depth parameters");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } stateT;

   stateT                 r_state;
   stateT                 w_stateNext;
   logic [ADDRWIDTHA-1:0] r_wrPtr;
   logic [ADDRWIDTHA-1:0] w_ptrNext;
   logic                  r_wrFull;
   logic                  w_fullNext;
   logic                  r_wrDone;
   logic                  w_doneNext;
   logic                  w_accept;
   logic                  w_wrReady;
   logic                  r_wrPend;
   logic [ADDRWIDTHA-1:0] r_wrAddr;
   logic [DATAWIDTHA-1:0] r_wrData;

   // Content is a configuration-time image, so the reset never touches it.
   (* ram_style = RAM_STYLE *)
   logic [c_RATIO-1:0][DATAWIDTHA-1:0] r_mem [SIZEB] = '{default: {c_RATIO{INIT_VALUE}}};

   always_comb begin
      w_stateNext = r_state;
      w_ptrNext   = r_wrPtr;
      w_fullNext  = r_wrFull;
      w_doneNext  = 1'b0;
      w_accept    = 1'b0;
      w_wrReady   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.wr_start) begin
               w_ptrNext   = bus.wr_base;
               w_fullNext  = 1'b0;
               w_stateNext = LOAD;
            end
         end
         LOAD: begin
            w_wrReady = !bus.wr_start;
            if (bus.wr_start) begin
               w_ptrNext = bus.wr_base;
            end else if (bus.wr_valid) begin
               w_accept = 1'b1;
               // The pointer parks on the top address instead of wrapping.
               if (r_wrPtr == c_TOP_ADDR) begin
                  w_fullNext = 1'b1;
               end else begin
                  w_ptrNext = r_wrPtr + 1'b1;
               end
               if (bus.wr_last || r_wrPtr == c_TOP_ADDR) begin
                  w_doneNext  = 1'b1;
                  w_stateNext = IDLE;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_wrPtr  <= '0;
         r_wrFull <= 1'b0;
         r_wrDone <= 1'b0;
         r_wrPend <= 1'b0;
         r_wrAddr <= '0;
         r_wrData <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_wrPtr  <= w_ptrNext;
         r_wrFull <= w_fullNext;
         r_wrDone <= w_doneNext;
         r_wrPend <= w_accept;
         if (w_accept) begin
            r_wrAddr <= r_wrPtr;
            r_wrData <= bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_wrPend) begin
         r_mem[r_wrAddr[ADDRWIDTHA-1:c_LANE_BITS]][r_wrAddr[c_LANE_BITS-1:0]] <= r_wrData;
      end
   end

   // Later stages load only behind a valid beat so rd_data holds between results.
   logic                  r_rdVld  [RD_LATENCY];
   logic [DATAWIDTHB-1:0] r_rdData [RD_LATENCY];
`ifdef ASYM_RAM_COLLISION_EN
   logic                  r_rdCol  [RD_LATENCY];
   logic                  w_collide;
   assign w_collide = r_wrPend && (r_wrAddr[ADDRWIDTHA-1:c_LANE_BITS] == bus.rd_addr);
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < RD_LATENCY; k++) begin
            r_rdVld[k]  <= 1'b0;
            r_rdData[k] <= '0;
`ifdef ASYM_RAM_COLLISION_EN
            r_rdCol[k]  <= 1'b0;
`endif
         end
      end else begin
         r_rdVld[0] <= bus.rd_en;
         if (bus.rd_en) begin
            r_rdData[0] <= r_mem[bus.rd_addr];
         end
`ifdef ASYM_RAM_COLLISION_EN
         r_rdCol[0] <= bus.rd_en && w_collide;
`endif
         for (int k = 1; k < RD_LATENCY; k++) begin
            r_rdVld[k] <= r_rdVld[k-1];
            if (r_rdVld[k-1]) begin
               r_rdData[k] <= r_rdData[k-1];
            end
`ifdef ASYM_RAM_COLLISION_EN
            r_rdCol[k] <= r_rdCol[k-1];
`endif
         end
      end
   end

   assign bus.wr_ready = w_wrReady;
   assign bus.wr_ptr   = r_wrPtr;
   assign bus.wr_done  = r_wrDone;
   assign bus.wr_full  = r_wrFull;
   assign bus.rd_data  = r_rdData[RD_LATENCY-1];
   assign bus.rd_valid = r_rdVld[RD_LATENCY-1];
`ifdef ASYM_RAM_COLLISION_EN
   assign bus.rd_collide = r_rdCol[RD_LATENCY-1];
`endif
endmodule
`default_nettype wire

// File: doc/asym_ram_stream_rdwide.md
Name: asym_ram_stream_rdwide

Overview:
Single-clock asymmetric simple-dual-port RAM. The narrow write side is a streaming loader with an auto-incrementing pointer and a valid/ready handshake. The wide read side is random-access, with a parametrised pipeline latency and a valid strobe. It is used to bulk-load waveform/envelope tables word by word from the host side and read them back as wide vectors by the DSP datapath.

Parameters:
DATAWIDTHA, 32, narrow write word width.
DATAWIDTHB, 512, wide read word width; must be an integer power-of-2 multiple of DATAWIDTHA.
SIZEB, 1024, depth in wide words.
ADDRWIDTHB, 10, read address width; log2(SIZEB).
ADDRWIDTHA, 14, write address width; ADDRWIDTHB + log2(DATAWIDTHB/DATAWIDTHA).
RD_LATENCY, 3, cycles from rd_en to rd_valid; legal range 1..8.
RAM_STYLE, "block", synthesis ram_style attribute.
INIT_VALUE, 32'h7fff0000, initial content of every narrow word at configuration; not restored by reset.

Ports:
clk  in  1  single clock for both sides.
rstn  in  1  asynchronous active-low reset.
wr_start  in  1  pulse: begin a load at wr_base.
wr_base  in  ADDRWIDTHA  narrow start address, sampled with wr_start.
wr_valid  in  1  write beat valid.
wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
wr_data  in  DATAWIDTHA  write beat data.
wr_last  in  1  final beat of the load.
wr_ptr  out  ADDRWIDTHA  address the next accepted beat will write.
wr_done  out  1  one-cycle pulse at load end.
wr_full  out  1  sticky: load stopped at the top address.
rd_en  in  1  read request.
rd_addr  in  ADDRWIDTHB  wide read address.
rd_data  out  DATAWIDTHB  read data; narrow word at address {rd_addr,k} occupies lane k, lane 0 in the LSBs.
rd_valid  out  1  rd_data valid.

Behaviour:
- Reset values (async assert, sync release):
  - state = IDLE.
  - wr_ptr = 0, wr_ready = 0, wr_done = 0, wr_full = 0.
  - rd_valid = 0, rd_data = 0; all read pipeline stages cleared.
  - Any registered write not yet committed is discarded.
  - RAM contents are untouched.
- Write FSM states:
  - IDLE: wr_ready = 0. On wr_start: wr_ptr <= wr_base, wr_full <= 0, go to LOAD.
  - LOAD: wr_ready = !wr_start.
    - Accepted beat: registered write RAM[wr_ptr] <= wr_data, committed the next cycle.
    - If wr_last: wr_done pulses the next cycle, go to IDLE.
    - Else if wr_ptr == SIZEB*RATIO-1: wr_full <= 1, wr_done pulses, go to IDLE.
    - Else wr_ptr <= wr_ptr+1.
  - wr_start in LOAD restarts the load at wr_base; the beat presented that cycle is not accepted. wr_full and the pending commit are unaffected.
  - wr_last and a top-address beat in the same cycle: wr_done pulses once and wr_full is set.
  - wr_valid in IDLE is ignored.
  - No wrap-around: a load never writes past the top address.
- Read pipeline:
  - rd_en at cycle t produces rd_valid = 1 at t+RD_LATENCY, with rd_data = RAM contents at cycle t.
  - Back-to-back rd_en every cycle gives one result per cycle.
  - rd_data holds its last value while rd_valid = 0.
- Write/read ordering:
  - A beat accepted at cycle t is visible to reads issued at t+2 or later.
  - Reads at t or t+1 return the old lane value; other lanes are unaffected.

Optional Feature:
ASYM_RAM_COLLISION_EN.
- Defined: adds output rd_collide (1 bit), aligned with rd_valid. It is high when the read was issued in the same cycle as a write commit to the same wide word (commit address >> log2(RATIO) == rd_addr). Reset value 0.
- Undefined: port absent; no collision logic; read data behaviour is identical either way.

Test Plan:
- Reset, then wr_start with wr_base=0; stream 16 beats 0x00000000..0x0000000F with wr_last on beat 16 → wr_done pulses once, wr_ptr=16. A read of rd_addr=0 gives rd_valid after exactly 3 cycles, with lane k = k.
- Default-content read: with no prior load, read rd_addr=5 → every 32-bit lane = 0x7fff0000.
- Top-address load: wr_base=16382, 4 beats, no wr_last → beats 1–2 accepted, wr_full=1, wr_done pulse, wr_ready=0 afterwards; addresses 0 and 1 are unchanged.
- Read ordering: accept beat 0xDEADBEEF to narrow addr 17 at cycle t; reads of rd_addr=1 at t and t+1 return old lane 1, and the read at t+2 returns 0xDEADBEEF. With ASYM_RAM_COLLISION_EN, rd_collide=1 only for the t+1 read.
- Restart mid-load: 3 beats from wr_base=100, then wr_start with wr_base=200 while wr_valid is high → that beat is not accepted, wr_ptr=200, and the next beat lands at 200.
- Reset mid-load: drop rstn for 1 cycle while beats and reads are in flight → outputs return to reset values immediately, no rd_valid emerges from flushed requests, and previously committed RAM words read back intact.
